// File: rtl/sin_sqrt_pkg.sv
// rtl/sin_sqrt_pkg.sv - shared widths, types and sine-table helpers for sin_sqrt_core
package sin_sqrt_pkg;

  localparam int PH_W     = 12;
  localparam int AMP      = 2047;
  localparam int SQ_IN_W  = 23;
  localparam int SQ_OUT_W = 12;

  typedef logic signed [PH_W-1:0] sample_t;
  typedef logic [SQ_OUT_W-1:0]    root_t;

  // Quarter-wave table entry: round(AMP*sin(pi*idx/2048)), always non-negative
  function automatic logic [10:0] quarter_sin(input int idx);
    real a;
    a = real'(AMP) * $sin(3.14159265358979323846 * real'(idx) / 2048.0);
    return 11'($rtoi(a + 0.5));
  endfunction

  // Table address: direct in quadrants 0/2, mirrored (1024-idx) in quadrants 1/3
  function automatic logic [9:0] rom_addr(input logic [10:0] ph);
    return ph[10] ? (10'd0 - ph[9:0]) : ph[9:0];
  endfunction

  // Apply the quadrant peak special case and the sign of the lower half-turn
  function automatic sample_t fold_sample(input logic [PH_W-1:0] ph, input logic [10:0] t);
    logic [10:0] mag;
    mag = (ph[10] && (ph[9:0] == 10'd0)) ? 11'(AMP) : t;
    return ph[11] ? -sample_t'({1'b0, mag}) : sample_t'({1'b0, mag});
  endfunction

endpackage

// File: rtl/sin_sqrt_if.sv
// rtl/sin_sqrt_if.sv - datapath bundle for sin_sqrt_core; COSs_o exists only with SIN_SQRT_COS_EN
interface sin_sqrt_if;
  import sin_sqrt_pkg::*;

  logic [PH_W-1:0]    PHs_i;
  sample_t            SINs_o;
  logic [SQ_IN_W-1:0] SQU_DATs_i;
  root_t              ROOTs_o;
`ifdef SIN_SQRT_COS_EN
  sample_t            COSs_o;

  modport master (output PHs_i, output SQU_DATs_i, input SINs_o, input ROOTs_o, input COSs_o);
  modport slave  (input PHs_i, input SQU_DATs_i, output SINs_o, output ROOTs_o, output COSs_o);
`else
  modport master (output PHs_i, output SQU_DATs_i, input SINs_o, input ROOTs_o);
  modport slave  (input PHs_i, input SQU_DATs_i, output SINs_o, output ROOTs_o);
`endif

endinterface

// File: rtl/sin_sqrt_isqrt_pipe.sv
// rtl/sin_sqrt_isqrt_pipe.sv - restoring integer square root, one result bit per pipeline stage
module isqrt_pipe #(
  parameter int SQ_IN_W = 23
) (
  input  logic                     CK_i,
  input  logic                     RST_i,
  input  logic [SQ_IN_W-1:0]       i_rad,
  output logic [(SQ_IN_W+1)/2-1:0] o_root
);

  localparam int OW = (SQ_IN_W + 1) / 2;
  localparam int PW = 2 * OW;
  localparam int RW = OW + 2;

  for (genvar s = 0; s < OW; s++) begin : g_st
    localparam int SH = 2 * (OW - 1 - s);

    logic [PW-1:0] w_rad;
    logic [RW-1:0] w_rem_prev;
    logic [OW-1:0] w_root_prev;
    logic [1:0]    w_pair;
    logic [RW-1:0] w_rem_sh;
    logic [RW-1:0] w_trial;
    logic          w_take;
    logic [OW-1:0] r_root;

    if (s == 0) begin : g_in
      assign w_rad       = PW'(i_rad);
      assign w_rem_prev  = '0;
      assign w_root_prev = '0;
    end else begin : g_chain
      assign w_rad       = g_st[s-1].g_carry.r_rad;
      assign w_rem_prev  = g_st[s-1].g_carry.r_rem;
      assign w_root_prev = g_st[s-1].r_root;
    end

    // Bring down the next radicand bit pair and try root bit = 1
    assign w_pair   = 2'(w_rad >> SH);
    assign w_rem_sh = RW'({w_rem_prev, w_pair});
    assign w_trial  = RW'({w_root_prev, 2'b01});
    assign w_take   = (w_rem_sh >= w_trial);

    // Partial root register, gains one bit per stage
    always_ff @(posedge CK_i) begin
      if (RST_i) r_root <= '0;
      else       r_root <= OW'({w_root_prev, w_take});
    end

    if (s < OW - 1) begin : g_carry
      logic [PW-1:0] r_rad;
      logic [RW-1:0] r_rem;

      // Radicand and remainder travel alongside the root to the next stage
      always_ff @(posedge CK_i) begin
        if (RST_i) begin
          r_rad <= '0;
          r_rem <= '0;
        end else begin
          r_rad <= w_rad;
          r_rem <= w_take ? (w_rem_sh - w_trial) : w_rem_sh;
        end
      end
    end
  end

  assign o_root = g_st[OW-1].r_root;

endmodule

// File: rtl/sin_sqrt_core.sv
// rtl/sin_sqrt_core.sv - quarter-wave sine lookup and pipelined sqrt; SIN_SQRT_COS_EN adds COSs_o
module sin_sqrt_core
  import sin_sqrt_pkg::*;
(
  input  logic      CK_i,
  input  logic      RST_i,
  sin_sqrt_if.slave bus
);

  logic [10:0] w_rom [1024];

  for (genvar g = 0; g < 1024; g++) begin : g_rom
    assign w_rom[g] = quarter_sin(g);
  end

  logic [9:0] w_sin_addr;
  sample_t    w_sin_next;
  sample_t    r_sin;

  assign w_sin_addr = rom_addr(bus.PHs_i[10:0]);
  assign w_sin_next = fold_sample(bus.PHs_i, w_rom[w_sin_addr]);

  // Sine output register, one cycle after the phase is sampled
  always_ff @(posedge CK_i) begin
    if (RST_i) r_sin <= '0;
    else       r_sin <= w_sin_next;
  end

  assign bus.SINs_o = r_sin;

`ifdef SIN_SQRT_COS_EN
  logic [PH_W-1:0] w_cos_ph;
  logic [9:0]      w_cos_addr;
  sample_t         w_cos_next;
  sample_t         r_cos;

  assign w_cos_ph   = bus.PHs_i + 12'h400;
  assign w_cos_addr = rom_addr(w_cos_ph[10:0]);
  assign w_cos_next = fold_sample(w_cos_ph, w_rom[w_cos_addr]);

  // Cosine output register, aligned with the sine register
  always_ff @(posedge CK_i) begin
    if (RST_i) r_cos <= '0;
    else       r_cos <= w_cos_next;
  end

  assign bus.COSs_o = r_cos;
`endif

  isqrt_pipe #(
    .SQ_IN_W (SQ_IN_W)
  ) u_isqrt (
    .CK_i   (CK_i),
    .RST_i  (RST_i),
    .i_rad  (bus.SQU_DATs_i),
    .o_root (bus.ROOTs_o)
  );

endmodule

// File: tb/tb_sin_sqrt_core.sv
// tb/tb_sin_sqrt_core.sv - directed and table-driven bench for sin_sqrt_core
module tb_sin_sqrt_core;
  import sin_sqrt_pkg::*;

  typedef struct {
    logic [11:0] ph;
    int          exp;
  } sin_vec_t;

  typedef struct {
    logic [22:0] x;
    int          exp;
  } sq_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sin_sqrt_if bus ();

  sin_sqrt_core dut (
    .CK_i  (clk),
    .RST_i (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_root(input string name, input longint x, input longint r);
    n_chk++;
    if (!((r * r <= x) && (x < (r + 1) * (r + 1)))) begin
      n_fail++;
      $display("FAIL %s: got root %0d for radicand %0d", name, r, x);
    end
  endtask

  function automatic int model_sin(input int k);
    real v;
    v = 2047.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 4096.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  initial begin
    sin_vec_t sv[12];
    sq_vec_t  qv[10];
    int       res[4096];
    int       mx;
    int       mn;
    logic     pv[12];
    int       px[12];
    int       x;
    logic     rst_now;

    sv[0]  = '{12'h000, 0};
    sv[1]  = '{12'h400, 2047};
    sv[2]  = '{12'h800, 0};
    sv[3]  = '{12'hC00, -2047};
    sv[4]  = '{12'h200, 1447};
    sv[5]  = '{12'h600, 1447};
    sv[6]  = '{12'hA00, -1447};
    sv[7]  = '{12'hE00, -1447};
    sv[8]  = '{12'h001, 3};
    sv[9]  = '{12'hFFF, -3};
    sv[10] = '{12'h3FF, 2047};
    sv[11] = '{12'h7FF, 3};

    qv[0] = '{23'd0, 0};
    qv[1] = '{23'd1, 1};
    qv[2] = '{23'd3, 1};
    qv[3] = '{23'd4, 2};
    qv[4] = '{23'd8386815, 2895};
    qv[5] = '{23'd8386816, 2896};
    qv[6] = '{23'd8388607, 2896};
    qv[7] = '{23'd15, 3};
    qv[8] = '{23'd16, 4};
    qv[9] = '{23'd1000000, 1000};

    // reset state with non-trivial inputs present
    bus.PHs_i      = 12'h400;
    bus.SQU_DATs_i = 23'd8388607;
    rst            = 1'b1;
    step();
    step();
    check("reset_sin", bus.SINs_o, 0);
    check("reset_root", bus.ROOTs_o, 0);
`ifdef SIN_SQRT_COS_EN
    check("reset_cos", bus.COSs_o, 0);
`endif
    bus.SQU_DATs_i = '0;
    rst            = 1'b0;

    // sine table vectors, one cycle latency each
    for (int i = 0; i < 12; i++) begin
      bus.PHs_i = sv[i].ph;
      step();
      check($sformatf("sin_vec_%0h", sv[i].ph), bus.SINs_o, sv[i].exp);
    end

    // full sweep against the real-number model
    mx = -5000;
    mn = 5000;
    for (int k = 0; k < 4096; k++) begin
      bus.PHs_i = 12'(k);
      step();
      res[k] = int'(bus.SINs_o);
      check($sformatf("sin_sweep_%0d", k), res[k], model_sin(k));
`ifdef SIN_SQRT_COS_EN
      check($sformatf("cos_sweep_%0d", k), bus.COSs_o, model_sin((k + 1024) % 4096));
`endif
      if (res[k] > mx) mx = res[k];
      if (res[k] < mn) mn = res[k];
    end
    for (int k = 0; k < 2048; k++) begin
      check($sformatf("sin_symm_%0d", k), res[k], -res[k + 2048]);
    end
    check("sin_max", mx, 2047);
    check("sin_min", mn, -2047);

    // sqrt edge values back-to-back; output stays 0 until the first result
    for (int i = 0; i < 10 + 11; i++) begin
      bus.SQU_DATs_i = (i < 10) ? qv[i].x : 23'd0;
      step();
      if (i >= 11) check($sformatf("sqrt_edge_%0d", qv[i-11].x), bus.ROOTs_o, qv[i-11].exp);
      else         check($sformatf("sqrt_fill_%0d", i), bus.ROOTs_o, 0);
    end

    // random sqrt stream with a one-cycle reset in the middle
    for (int j = 0; j < 12; j++) begin
      pv[j] = 1'b0;
      px[j] = 0;
    end
    bus.PHs_i = 12'h400;
    for (int t = 0; t < 10000; t++) begin
      x              = int'($urandom_range(0, 8388607));
      rst_now        = (t == 5000);
      rst            = rst_now;
      bus.SQU_DATs_i = 23'(x);
      step();
      rst = 1'b0;
      if (rst_now) begin
        for (int j = 0; j < 12; j++) pv[j] = 1'b0;
      end else begin
        for (int j = 11; j > 0; j--) begin
          pv[j] = pv[j-1];
          px[j] = px[j-1];
        end
        pv[0] = 1'b1;
        px[0] = x;
      end
      check($sformatf("rnd_sin_%0d", t), bus.SINs_o, rst_now ? 0 : 2047);
      if (pv[11]) check_root($sformatf("rnd_root_%0d", t), px[11], bus.ROOTs_o);
      else        check($sformatf("rnd_root_zero_%0d", t), bus.ROOTs_o, 0);
    end

`ifdef SIN_SQRT_COS_EN
    // cosine cardinal points, aligned with sine
    bus.PHs_i = 12'h000;
    step();
    check("cos_000", bus.COSs_o, 2047);
    check("cos_000_sin", bus.SINs_o, 0);
    bus.PHs_i = 12'h400;
    step();
    check("cos_400", bus.COSs_o, 0);
    check("cos_400_sin", bus.SINs_o, 2047);
    bus.PHs_i = 12'h800;
    step();
    check("cos_800", bus.COSs_o, -2047);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
